// File: rtl/rr_arb_pkg.sv
// Shared types and sizing for the eight-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage : rr_arb_pkg

// File: rtl/idx_dec3to8.sv
// Combinational 3-to-8 one-hot decoder: out_c[k] = (idx == k).
module idx_dec3to8
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] out_c
);

  always_comb begin
    out_c = '0;
    for (int k = 0; k < N_REQ; k++) begin
      out_c[k] = (idx == IDX_W'(k));
    end
  end

endmodule : idx_dec3to8

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter, grant held until owner drops req.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arb8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             preempt
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               gnt_vld_q, gnt_vld_d;
  logic               preempt_q, preempt_d;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   win_idx;
  logic [N_REQ-1:0]   dec_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD != 0);
`endif

  // Rotate req so that bit 0 is the requester at ptr, find first one, add ptr back.
  always_comb begin
    req_rot   = '0;
    first_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_rot[i] = req[IDX_W'(i) + ptr_q];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) first_idx = IDX_W'(i);
    end
    win_idx = first_idx + ptr_q;
  end

  idx_dec3to8 u_dec (
    .idx   (gnt_idx_d),
    .out_c (dec_c)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    preempt_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_BUSY;
          gnt_idx_d = win_idx;
          ptr_d     = win_idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (!req[gnt_idx_q]) begin
          state_d = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d   = ST_IDLE;
          preempt_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    gnt_vld_d = (state_d == ST_BUSY);
    gnt_d     = gnt_vld_d ? dec_c : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      preempt_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      preempt_q <= preempt_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign preempt = preempt_q;

endmodule : rr_arb8

// File: tb/tb_rr_arb8.sv
// Directed self-checking bench for rr_arb8 (default build and ARB_TIMEOUT_EN with MAX_HOLD=4).
module tb_rr_arb8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  rr_arb8 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    #2;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_idx", 8'(gnt_idx), 8'h00);
    chk("rst_vld", 8'(gnt_vld), 8'h00);
    chk("rst_pre", 8'(preempt), 8'h00);
    #10 rst_n = 1'b1;

    // No requests: nothing granted.
    for (int c = 0; c < 5; c++) begin
      step();
      chk("idle_gnt", gnt, 8'h00);
      chk("idle_vld", 8'(gnt_vld), 8'h00);
      chk("idle_pre", 8'(preempt), 8'h00);
    end

    // 0x81 from ptr=0: 0 wins, then 7 after one idle cycle.
    req = 8'h81;
    step();
    chk("t2_gnt0", gnt, 8'h01);
    chk("t2_idx0", 8'(gnt_idx), 8'h00);
    chk("t2_vld0", 8'(gnt_vld), 8'h01);
    req = 8'h80;
    step();
    chk("t2_gap", gnt, 8'h00);
    chk("t2_gapv", 8'(gnt_vld), 8'h00);
    step();
    chk("t2_gnt7", gnt, 8'h80);
    chk("t2_idx7", 8'(gnt_idx), 8'h07);
    req = 8'h00;
    step();
    chk("t2_rel", gnt, 8'h00);
    chk("t2_idxhold", 8'(gnt_idx), 8'h07);

    // All request, each owner holds two cycles: order 0..7 then wrap to 0.
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("rr_gnt_a", gnt, 8'h01 << (k % 8));
      chk("rr_idx", 8'(gnt_idx), 8'(k % 8));
      step();
      chk("rr_gnt_b", gnt, 8'h01 << (k % 8));
      req = 8'hFF & ~(8'h01 << (k % 8));
      step();
      chk("rr_gap", gnt, 8'h00);
      req = 8'hFF;
    end
    req = 8'h00;
    step();
    chk("rr_end", gnt, 8'h00);

    // ptr=1: owner 3 holds while req[5] toggles.
    req = 8'h08;
    step();
    chk("hold_gnt", gnt, 8'h08);
    for (int c = 0; c < 4; c++) begin
      req = (c % 2 == 0) ? 8'h28 : 8'h08;
      step();
      chk("hold_keep", gnt, 8'h08);
    end
    req = 8'h20;
    step();
    chk("hold_rel", gnt, 8'h00);
    step();
    chk("hold_next", gnt, 8'h20);
    chk("hold_nidx", 8'(gnt_idx), 8'h05);
    req = 8'h00;
    step();

    // ptr=6: grant 4, then async reset mid-grant.
    req = 8'h10;
    step();
    chk("ar_pre", gnt, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", gnt, 8'h00);
    chk("ar_vld", 8'(gnt_vld), 8'h00);
    chk("ar_idx", 8'(gnt_idx), 8'h00);
    req = 8'h30;
    #2 rst_n = 1'b1;
    step();
    chk("ar_regnt", gnt, 8'h10);
    chk("ar_reidx", 8'(gnt_idx), 8'h04);
    req = 8'h00;
    step();
    chk("ar_rel", gnt, 8'h00);

    // ptr=5: single-cycle request gives a single-cycle grant.
    req = 8'h01;
    step();
    chk("pulse_gnt", gnt, 8'h01);
    req = 8'h00;
    step();
    chk("pulse_rel", gnt, 8'h00);

    // ptr=1: 0x06 held, requester 1 wins.
    req = 8'h06;
    step();
    chk("to_gnt1", gnt, 8'h02);
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      step();
      chk("to_hold", gnt, 8'h02);
      chk("to_nopre", 8'(preempt), 8'h00);
    end
    step();
    chk("to_cut", gnt, 8'h00);
    chk("to_pre", 8'(preempt), 8'h01);
    step();
    chk("to_gnt2", gnt, 8'h04);
    chk("to_pre0", 8'(preempt), 8'h00);
`else
    for (int c = 0; c < 20; c++) begin
      step();
      chk("nto_hold", gnt, 8'h02);
      chk("nto_pre", 8'(preempt), 8'h00);
    end
`endif
    req = 8'h00;
    step();
    chk("final_rel", gnt, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_arb8
